// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel APB register block: register offsets,
// field positions and the APB handshake state type.
package dma_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_SRC    = 8'h04;
    localparam logic [7:0] REG_DST    = 8'h08;
    localparam logic [7:0] REG_LEN    = 8'h0C;
    localparam logic [7:0] REG_STATUS = 8'h10;
    localparam logic [7:0] REG_ID     = 8'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_ERR      = 2;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_ACCESS = 2'd1,
        APB_RESP   = 2'd2
    } apb_state_e;

endpackage

// File: rtl/dma_apb_fsm.sv
// APB slave handshake: every transfer takes one wait state, pready is high for
// exactly the RESP cycle, and the word address is captured at setup.
//
// state      | meaning
// APB_IDLE   | waiting for a setup phase (psel & !penable)
// APB_ACCESS | access phase, wait state; read data is loaded leaving here
// APB_RESP   | pready=1; a write commits on the edge ending this cycle
module dma_apb_fsm
    import dma_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    output logic       pready,
    output logic       wr_en,
    output logic       rd_en,
    output logic [5:0] addr_word
);

    apb_state_e state_q, state_d;
    logic [5:0] addr_q, addr_d;

    // Byte lanes within a word are not decoded.
    logic unused_paddr;
    assign unused_paddr = ^paddr[1:0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= APB_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pready  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (psel && !penable) begin
                    state_d = APB_ACCESS;
                    addr_d  = paddr[7:2];
                end
            end
            APB_ACCESS: begin
                if (psel && penable) begin
                    state_d = APB_RESP;
                    rd_en   = !pwrite;
                end else begin
                    state_d = APB_IDLE;
                end
            end
            APB_RESP: begin
                pready  = 1'b1;
                wr_en   = psel && penable && pwrite;
                state_d = APB_IDLE;
            end
            default: state_d = APB_IDLE;
        endcase
    end

    assign addr_word = addr_q;

endmodule

// File: rtl/dma_apb_regs.sv
// DMA channel configuration/status registers behind an APB slave port:
// start pulse generation, busy/done/err tracking and a level interrupt.
module dma_apb_regs
    import dma_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int          LEN_W  = 16,
    parameter logic [31:0] ID_VAL = 32'h444D_4101
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic [7:0]        paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic [ADDR_W-1:0] cfg_src,
    output logic [ADDR_W-1:0] cfg_dst,
    output logic [LEN_W-1:0]  cfg_len,
    output logic              dma_start,
    input  logic              eng_done,
    input  logic              eng_err,
    output logic              irq
);

    logic       wr_en, rd_en;
    logic [5:0] addr_word;
    logic [7:0] byte_addr;

    dma_apb_fsm u_fsm (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pready    (pready),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr_word (addr_word)
    );

    assign byte_addr = {addr_word, 2'b00};

    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              irq_en_q, irq_en_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              start_q, start_d, irq_q, irq_d;
    logic [DATA_W-1:0] prdata_q, prdata_d, rdata;

    logic wr_ctrl, wr_src, wr_dst, wr_len, wr_status;
    logic start_req, start_ok, start_bad;

    assign wr_ctrl   = wr_en && (byte_addr == REG_CTRL);
    assign wr_src    = wr_en && (byte_addr == REG_SRC);
    assign wr_dst    = wr_en && (byte_addr == REG_DST);
    assign wr_len    = wr_en && (byte_addr == REG_LEN);
    assign wr_status = wr_en && (byte_addr == REG_STATUS);

    // busy_q is the pre-edge value, so a START coincident with eng_done is dropped.
    assign start_req = wr_ctrl && pwdata[CTRL_START] && !busy_q;
    assign start_ok  = start_req && (len_q != '0);
    assign start_bad = start_req && (len_q == '0);

    always_comb begin
        rdata = '0;
        case (byte_addr)
            REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
            REG_SRC:    rdata = DATA_W'(src_q);
            REG_DST:    rdata = DATA_W'(dst_q);
            REG_LEN:    rdata = DATA_W'(len_q);
            REG_STATUS: begin
                rdata[ST_BUSY] = busy_q;
                rdata[ST_DONE] = done_q;
                rdata[ST_ERR]  = err_q;
            end
            REG_ID:     rdata = DATA_W'(ID_VAL);
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        if (wr_src && !busy_q) src_d = pwdata[ADDR_W-1:0];
        if (wr_dst && !busy_q) dst_d = pwdata[ADDR_W-1:0];
        if (wr_len && !busy_q) len_d = pwdata[LEN_W-1:0];
        if (wr_ctrl)           irq_en_d = pwdata[CTRL_IRQ_EN];
        if (eng_done || eng_err) busy_d = 1'b0;
        if (start_ok)            busy_d = 1'b1;
        // Hardware set is applied after W1C so it wins on a collision.
        if (wr_status && pwdata[ST_DONE]) done_d = 1'b0;
        if (eng_done)                     done_d = 1'b1;
        if (wr_status && pwdata[ST_ERR])  err_d = 1'b0;
        if (eng_err || start_bad)         err_d = 1'b1;
        start_d  = start_ok;
        irq_d    = irq_en_q && (done_q || err_q);
        prdata_d = rd_en ? rdata : '0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
            prdata_q <= prdata_d;
        end
    end

    assign cfg_src   = src_q;
    assign cfg_dst   = dst_q;
    assign cfg_len   = len_q;
    assign dma_start = start_q;
    assign irq       = irq_q;
    assign prdata    = prdata_q;

endmodule

// File: tb/tb_dma_apb_regs.sv
// Scoreboard bench for dma_apb_regs: directed scenarios plus random traffic
// checked against a behavioural register model.
module tb_dma_apb_regs;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready;
    logic [31:0] cfg_src, cfg_dst;
    logic [15:0] cfg_len;
    logic        dma_start, eng_done, eng_err, irq;

    always #5 pclk = ~pclk;

    dma_apb_regs dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .dma_start (dma_start),
        .eng_done  (eng_done),
        .eng_err   (eng_err),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int starts_seen = 0;

    typedef struct {
        bit          is_read;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_src, m_dst;
    logic [15:0] m_len;
    bit          m_irq_en, m_busy, m_done, m_err, m_started_now;
    int          m_starts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_len = '0;
        m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_started_now = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a[7:2])
            6'd0:    return {30'b0, m_irq_en, 1'b0};
            6'd1:    return m_src;
            6'd2:    return m_dst;
            6'd3:    return {16'b0, m_len};
            6'd4:    return {29'b0, m_err, m_done, m_busy};
            6'd5:    return 32'h444D_4101;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        case (a[7:2])
            6'd0: begin
                m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    if (m_len != 0) begin
                        m_busy = 1; m_starts++; m_started_now = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            6'd1: if (!m_busy) m_src = d;
            6'd2: if (!m_busy) m_dst = d;
            6'd3: if (!m_busy) m_len = d[15:0];
            6'd4: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_engine(input bit d, input bit e);
        if (d || e) m_busy = 0;
        if (d) m_done = 1;
        if (e) m_err = 1;
    endtask

    // One APB transfer; optional engine pulses are held during the RESP cycle.
    task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input bit ed, input bit ee);
        exp_t e;
        e.is_read = !wr;
        e.addr    = a;
        e.data    = wr ? 32'h0 : model_read(a);
        sb_q.push_back(e);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        chk1("pready_access", pready, 1'b0);
        penable = 1;
        @(posedge pclk); #1;
        chk1("pready_resp", pready, 1'b1);
        eng_done = ed; eng_err = ee;
        @(posedge pclk); #1;
        psel = 0; penable = 0; eng_done = 0; eng_err = 0;
        m_started_now = 0;
        if (wr) model_write(a, d);
        model_engine(ed, ee);
        chk1("pready_after", pready, 1'b0);
        chk1("dma_start_after_commit", dma_start, m_started_now);
        chk("cfg_src", cfg_src, m_src);
        chk("cfg_dst", cfg_dst, m_dst);
        chk("cfg_len", {16'b0, cfg_len}, {16'b0, m_len});
    endtask

    task automatic pulse_eng(input bit d, input bit e);
        @(posedge pclk); #1;
        eng_done = d; eng_err = e;
        @(posedge pclk); #1;
        eng_done = 0; eng_err = 0;
        model_engine(d, e);
    endtask

    task automatic read_all();
        for (int i = 0; i < 6; i++) apb_xfer(0, 8'(i * 4), 32'h0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   prev_start;
        prev_start = 0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                prev_start = 0;
                continue;
            end
            if (pready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got 1, expected 0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) chk($sformatf("read_%02h", e.addr), prdata, e.data);
                end
            end else begin
                chk("prdata_idle", prdata, 32'h0);
            end
            if (dma_start) begin
                starts_seen++;
                chk1("dma_start_width", prev_start, 1'b0);
            end
            prev_start = dma_start;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    logic [7:0]  offs [8];
    logic [7:0]  a;
    logic [31:0] d;
    int          k;

    initial begin : stim
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h3C};
        presetn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        eng_done = 0; eng_err = 0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        chk1("reset_pready", pready, 1'b0);
        chk1("reset_irq", irq, 1'b0);
        chk1("reset_dma_start", dma_start, 1'b0);
        presetn = 1;

        // Reset values
        read_all();

        // Address registers and readback
        apb_xfer(1, 8'h04, 32'h1000_0000, 0, 0);
        apb_xfer(1, 8'h08, 32'h2000_0040, 0, 0);
        apb_xfer(1, 8'h0C, 32'h0000_0100, 0, 0);
        read_all();

        // Start, done, irq and W1C
        apb_xfer(1, 8'h00, 32'h3, 0, 0);
        @(posedge pclk); #1;
        chk1("dma_start_falls", dma_start, 1'b0);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);
        pulse_eng(1, 0);
        chk1("irq_lags_done", irq, 1'b0);
        @(posedge pclk); #1;
        chk1("irq_after_done", irq, 1'b1);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);
        apb_xfer(1, 8'h10, 32'h2, 0, 0);
        chk1("irq_still_high", irq, 1'b1);
        @(posedge pclk); #1;
        chk1("irq_cleared", irq, 1'b0);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);

        // Busy lockout and set-vs-clear collisions
        apb_xfer(1, 8'h00, 32'h3, 0, 0);
        apb_xfer(1, 8'h04, 32'hDEAD_BEEF, 0, 0);
        apb_xfer(0, 8'h04, 32'h0, 0, 0);
        apb_xfer(1, 8'h00, 32'h1, 0, 0);
        apb_xfer(1, 8'h00, 32'h3, 1, 0);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);
        apb_xfer(1, 8'h10, 32'h2, 1, 0);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);

        // Zero length start and engine error
        apb_xfer(1, 8'h10, 32'h6, 0, 0);
        apb_xfer(1, 8'h0C, 32'h0, 0, 0);
        apb_xfer(1, 8'h00, 32'h1, 0, 0);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);
        apb_xfer(1, 8'h10, 32'h4, 0, 0);
        apb_xfer(1, 8'h0C, 32'h40, 0, 0);
        apb_xfer(1, 8'h00, 32'h3, 0, 0);
        pulse_eng(0, 1);
        apb_xfer(0, 8'h10, 32'h0, 0, 0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            a = offs[$urandom_range(0, 7)] | {6'b0, 2'($urandom_range(0, 3))};
            d = $urandom;
            if (a[7:2] == 6'd3 && $urandom_range(0, 3) == 0) d = 32'h0;
            if (k < 5) begin
                apb_xfer(1, a, d, 0, 0);
            end else if (k < 8 || !m_busy) begin
                apb_xfer(0, a, 32'h0, 0, 0);
            end else begin
                case ($urandom_range(0, 2))
                    0:       pulse_eng(1, 0);
                    1:       pulse_eng(0, 1);
                    default: pulse_eng(1, 1);
                endcase
            end
            @(posedge pclk); #1;
            chk1("irq_level", irq, m_irq_en & (m_done | m_err));
        end

        // Unmapped read, then reset in the middle of a transfer
        apb_xfer(0, 8'h3C, 32'h0, 0, 0);
        apb_xfer(1, 8'h04, 32'h1234_5678, 0, 0);
        apb_xfer(1, 8'h00, 32'h2, 0, 0);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 8'h14;
        @(posedge pclk); #1;
        penable = 1;
        #2;
        presetn = 0;
        #1;
        chk1("reset_mid_pready", pready, 1'b0);
        chk("reset_mid_prdata", prdata, 32'h0);
        chk("reset_mid_cfg_src", cfg_src, 32'h0);
        chk1("reset_mid_irq", irq, 1'b0);
        psel = 0; penable = 0;
        model_reset();
        @(posedge pclk); #1;
        presetn = 1;
        read_all();

        repeat (4) @(posedge pclk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        chk("dma_start_count", starts_seen, m_starts);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
